// File: rtl/comparador_scheduler_if.sv
// comparador_scheduler_if
//   Groups the requester bus and the result bus of comparador_scheduler.
//   master : requester/consumer side (drives req/data, observes results)
//   slave  : the scheduler (observes req/data, drives ack and results)
//   req[N]        per-requester request, held until its ack
//   data[4N]      operand nibbles, requester i owns data[4i+3:4i]
//   ack[N]        one-hot capture pulse
//   busy          transaction in flight
//   res_valid     one-cycle result strobe
//   res_match     captured operand equalled KEY
//   res_id[3]     requester index the result belongs to
//   match_count   saturating count of matching results
interface comparador_scheduler_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic [N-1:0]   req;
  logic [4*N-1:0] data;
  logic [N-1:0]   ack;
  logic           busy;
  logic           res_valid;
  logic           res_match;
  logic [2:0]     res_id;
  logic [CW-1:0]  match_count;

  modport master (
    output req, data,
    input  ack, busy, res_valid, res_match, res_id, match_count
  );

  modport slave (
    input  req, data,
    output ack, busy, res_valid, res_match, res_id, match_count
  );
endinterface

// File: rtl/comparador_scheduler.sv
// comparador_scheduler
//   Shares one registered 4-bit constant-equality comparator (XNOR + AND4)
//   among N requesters. A round-robin arbiter picks a requester in IDLE,
//   LOAD acks it and latches its nibble, CMP registers the compare, DONE
//   strobes the tagged result and bumps a saturating match counter.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : comparador_scheduler_if.slave (req/data in, ack/busy/results out)
module comparador_scheduler #(
  parameter int         N   = 4,
  parameter logic [3:0] KEY = 4'b0101,
  parameter int         CW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  comparador_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_ptr, r_win, r_res_id;
  logic [3:0]    r_operand;
  logic          r_cmp;
  logic [CW-1:0] r_count;

  logic [2*N-1:0] w_rot;
  logic           w_any;
  logic [2:0]     w_off, w_win, w_ptr_nxt;
  logic [3:0]     w_sum, w_ptr_sum;
  logic [3:0]     w_sel, w_xnor;
  logic           w_eq;
  logic [N-1:0]   w_ack;
  logic           w_busy, w_valid;

  // Round-robin search: rotate a doubled copy of req so bit j is requester
  // (rr_ptr + j) mod N, take the lowest set bit, then map back to an index.
  always_comb begin
    w_rot = {bus.req, bus.req} >> r_ptr;
    w_any = 1'b0;
    w_off = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_off = 3'(j);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= 4'(N)) w_sum = w_sum - 4'(N);
    w_win = w_sum[2:0];
  end

  always_comb begin
    w_ptr_sum = {1'b0, r_win} + 4'd1;
    w_ptr_nxt = (w_ptr_sum >= 4'(N)) ? 3'd0 : w_ptr_sum[2:0];
  end

  assign w_sel  = 4'(bus.data >> {r_win, 2'b00});
  assign w_xnor = ~(r_operand ^ KEY);
  assign w_eq   = &w_xnor;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ack   = '0;
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_next = LOAD;
      LOAD: begin
        w_ack  = {{(N-1){1'b0}}, 1'b1} << r_win;
        w_busy = 1'b1;
        w_next = CMP;
      end
      CMP: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_operand <= '0;
      r_cmp     <= 1'b0;
      r_res_id  <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) r_win <= w_win;
        LOAD: begin
          r_operand <= w_sel;
          r_ptr     <= w_ptr_nxt;
        end
        // res_id is copied here so it stays stable after DONE even though
        // r_win is overwritten by the next grant.
        CMP: begin
          r_cmp    <= w_eq;
          r_res_id <= r_win;
        end
        DONE: if (r_cmp && (r_count != '1)) r_count <= r_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ack         = w_ack;
  assign bus.busy        = w_busy;
  assign bus.res_valid   = w_valid;
  assign bus.res_match   = r_cmp;
  assign bus.res_id      = r_res_id;
  assign bus.match_count = r_count;

endmodule
